memory_system_pipelined: RTL
============================

# memory_system_pipelined

Parametrised successor to the single-cycle data memory: a word-organised RAM behind a valid/ready request port and a valid/ready response port. It adds byte-enable writes, address decode relative to a base address, configurable access latency and an error response for misaligned or out-of-range accesses. It sits between the processor's load/store stage and the data RAM and holds one outstanding request at a time.

## Interface
- MEMORY_DEPTH, 64, number of words.
- DATA_WIDTH, 32, word width in bits. Must be a multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- BASE_ADDRESS, 32'h1001_0000, byte address of word 0. Must be word-aligned.
- LATENCY, 1, cycles from request acceptance to response valid. Legal range 1..8.

Ports:
- clk  in  1  clock. All state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Req_Valid_i  in  1  request present.
- Req_Ready_o  out  1  block can accept a request.
- Write_Enable_i  in  1  1 = write, 0 = read.
- Byte_Enable_i  in  DATA_WIDTH/8  per-byte write mask. Ignored on reads.
- Address_i  in  ADDR_WIDTH  byte address.
- Write_Data_i  in  DATA_WIDTH  write data.
- Resp_Valid_o  out  1  response present.
- Resp_Ready_i  in  1  consumer takes the response.
- Data_o  out  DATA_WIDTH  response data.
- Error_o  out  1  response is an error. Qualified by Resp_Valid_o.

## Operation
- State machine states:
  - IDLE: Req_Ready_o=1.
  - WAIT: latency countdown.
  - RESP: Resp_Valid_o=1.
- IDLE to WAIT: on Req_Valid_i & Req_Ready_o at an edge.
  - Latch opcode, byte enables, address and write data.
  - Load the counter with LATENCY-1.
- WAIT:
  - Counter nonzero: decrement.
  - Counter zero: commit the access, register Data_o/Error_o, go to RESP.
- RESP to IDLE: at the edge where Resp_Ready_i=1. Otherwise hold; Data_o and Error_o stay stable.
- Decode:
  - offset = latched address − BASE_ADDRESS, computed in ADDR_WIDTH bits.
  - Error if offset's low log2(DATA_WIDTH/8) bits are nonzero.
  - Error if address < BASE_ADDRESS or offset ≥ MEMORY_DEPTH·DATA_WIDTH/8.
  - Otherwise, index = offset >> log2(DATA_WIDTH/8).
- Read commit: Data_o = mem[index], Error_o=0.
- Write commit:
  - Each byte lane b with Byte_Enable[b]=1 takes Write_Data byte b; other lanes keep their old value.
  - Data_o = resulting merged word, Error_o=0.
  - All-zero byte enable is legal: no change, Data_o = old word.
- Error commit: array unchanged, Data_o=0, Error_o=1.
- Req_Valid_i is ignored outside IDLE. Address_i/Write_Data_i may change after acceptance.
- Reset:
  - State IDLE, counter 0, Req_Ready_o=1, Resp_Valid_o=0, Data_o=0, Error_o=0.
  - Memory contents are not cleared.
  - Reset asserted during WAIT before the commit edge: the pending write is dropped and the word is unchanged.

## Timing
- Acceptance at edge N. Commit at edge N+LATENCY. Resp_Valid_o high from N+LATENCY until the handshake edge.
- Earliest next acceptance: the edge after the response handshake. Req_Ready_o rises combinationally in IDLE.
- Peak throughput: one access per LATENCY+2 cycles with Resp_Ready_i held high.
- Req_Ready_o and Resp_Valid_o are decoded from registered state only. No input-to-output combinational path.

## Structure
- Package memory_system_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - a request struct (we, be, addr, wdata);
  - a decode function returning {error, index}.
- Sub-module memory_array:
  - MEMORY_DEPTH × DATA_WIDTH storage, synchronous byte-enable write, combinational read.
  - No reset.
  - The controller registers its read output.

## Test plan
- Reset, then with LATENCY=1: write 32'hDEAD_BEEF to 0x1001_0004 with BE=4'hF, then read 0x1001_0004. Expect Data_o=32'hDEAD_BEEF, Error_o=0, Resp_Valid_o rising one cycle after each acceptance.
- Byte-enable merge: word 0 = 32'h1122_3344; write 32'hAABB_CCDD with BE=4'b0101. Expect write response and a subsequent read both = 32'h11BB_33DD.
- Errors:
  - Read at 0x1001_0002: Error_o=1, Data_o=0.
  - Write at 0x1001_0100 (DEPTH=64): Error_o=1, and the last word is unchanged on read-back.
  - Read at 0x1000_FFFC: Error_o=1.
- Backpressure with LATENCY=4: hold Resp_Ready_i=0 for 5 cycles after Resp_Valid_o. Expect Data_o stable, Req_Ready_o=0, and a second Req_Valid_i ignored. On release, the response completes and the next request is accepted one edge later.
- Reset mid-operation with LATENCY=4: accept a write of 32'h0 to a word holding 32'h5555_5555, then assert rst two cycles later. Expect all outputs at reset values immediately and a later read returning 32'h5555_5555.

Source files
------------

// File: rtl/memory_system_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_system_pkg                                                    |
// | Shared types and address decode for memory_system_pipelined.         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package memory_system_pkg;

  // Fields are sized for the widest supported configuration; users occupy the low bits.
  localparam int MAX_AW = 64;
  localparam int MAX_DW = 256;
  localparam int MAX_BE = MAX_DW / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic              we;
    logic [MAX_BE-1:0] be;
    logic [MAX_AW-1:0] addr;
    logic [MAX_DW-1:0] wdata;
  } req_t;

  typedef struct packed {
    logic              error;
    logic [MAX_AW-1:0] index;
  } decode_t;

  function automatic decode_t decode(
    input logic [MAX_AW-1:0] addr,
    input logic [MAX_AW-1:0] base,
    input int unsigned       aw,
    input int unsigned       bl,
    input int unsigned       depth
  );
    decode_t           res;
    logic [MAX_AW-1:0] mask;
    logic [MAX_AW-1:0] offset;
    logic [MAX_AW-1:0] limit;
    mask      = (aw >= MAX_AW) ? '1 : ((MAX_AW'(1) << aw) - MAX_AW'(1));
    offset    = (addr - base) & mask;
    limit     = MAX_AW'(depth) << bl;
    res.error = ((offset & ((MAX_AW'(1) << bl) - MAX_AW'(1))) != '0)
              || (addr < base) || (offset >= limit);
    res.index = offset >> bl;
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/memory_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_array                                                         |
// | Word storage with synchronous byte-enable write, combinational read. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_array #(
  parameter int DEPTH      = 64,
  parameter int DATA_WIDTH = 32,
  parameter int BYTES      = DATA_WIDTH / 8,
  parameter int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [BYTES-1:0]      be_i,
  input  logic [IDX_W-1:0]      idx_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be_i[b]) mem_q[idx_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule
`default_nettype wire

// File: rtl/memory_system_pipelined.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | memory_system_pipelined                                              |
// | Valid/ready RAM front end with latency, byte enables and errors.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module memory_system_pipelined
  import memory_system_pkg::*;
#(
  parameter int                    MEMORY_DEPTH = 64,
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = 'h1001_0000,
  parameter int                    LATENCY      = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Req_Valid_i,
  output logic                    Req_Ready_o,
  input  logic                    Write_Enable_i,
  input  logic [DATA_WIDTH/8-1:0] Byte_Enable_i,
  input  logic [ADDR_WIDTH-1:0]   Address_i,
  input  logic [DATA_WIDTH-1:0]   Write_Data_i,
  output logic                    Resp_Valid_o,
  input  logic                    Resp_Ready_i,
  output logic [DATA_WIDTH-1:0]   Data_o,
  output logic                    Error_o
);

  localparam int                BYTES    = DATA_WIDTH / 8;
  localparam int                BL       = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int                IDX_W    = (MEMORY_DEPTH > 1) ? $clog2(MEMORY_DEPTH) : 1;
  localparam int                CNT_W    = 3;
  localparam logic [MAX_AW-1:0] BASE_EXT = MAX_AW'(BASE_ADDRESS);

  state_e                state_q;
  logic [CNT_W-1:0]      cnt_q;
  req_t                  req_q;
  req_t                  req_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  decode_t               w_dec;
  logic                  w_commit;
  logic                  w_mem_we;
  logic [DATA_WIDTH-1:0] w_rdata;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_unused;

  always_comb begin
    req_d                        = '0;
    req_d.we                     = Write_Enable_i;
    req_d.be[BYTES-1:0]          = Byte_Enable_i;
    req_d.addr[ADDR_WIDTH-1:0]   = Address_i;
    req_d.wdata[DATA_WIDTH-1:0]  = Write_Data_i;
  end

  assign w_dec    = decode(req_q.addr, BASE_EXT, ADDR_WIDTH, BL, MEMORY_DEPTH);
  assign w_commit = (state_q == WAIT) && (cnt_q == '0);
  // Reset returns the FSM to IDLE asynchronously, so a pending write never reaches the array.
  assign w_mem_we = w_commit && req_q.we && !w_dec.error;
  assign w_unused = ^{w_dec.index, req_q.be, req_q.wdata};

  memory_array #(
    .DEPTH      (MEMORY_DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .BYTES      (BYTES),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk     (clk),
    .we_i    (w_mem_we),
    .be_i    (req_q.be[BYTES-1:0]),
    .idx_i   (w_dec.index[IDX_W-1:0]),
    .wdata_i (req_q.wdata[DATA_WIDTH-1:0]),
    .rdata_o (w_rdata)
  );

  always_comb begin
    w_merged = w_rdata;
    for (int b = 0; b < BYTES; b++) begin
      if (req_q.be[b]) w_merged[b*8 +: 8] = req_q.wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req_Valid_i) begin
            req_q   <= req_d;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else begin
            data_q  <= w_dec.error ? '0 : (req_q.we ? w_merged : w_rdata);
            err_q   <= w_dec.error;
            state_q <= RESP;
          end
        end
        RESP: begin
          if (Resp_Ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Req_Ready_o  = (state_q == IDLE);
  assign Resp_Valid_o = (state_q == RESP);
  assign Data_o       = data_q;
  assign Error_o      = err_q;

endmodule
`default_nettype wire
